addr8u_result_checker: RTL and testbench

//  Sequential consumer placed directly downstream of an 8-bit unsigned adder (A[7:0]+B[7:0] -> O[8:0]).

---
 rtl/addr8u_chk_pkg.sv | 22 ++
 rtl/addr8u_chk_fifo.sv | 57 +++++
 rtl/addr8u_result_checker.sv | 171 +++++++++++++++++
 tb/tb_addr8u_result_checker.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/addr8u_chk_pkg.sv
// Shared types and widths for the 8-bit adder result checker.
//   OP_W / SUM_W : operand and sum widths of the adder under test
//   chk_state_e  : checker FSM states (RUN, HALT)
//   chk_log_t    : failing-vector record {a, b, dut, exp}, a in the MSBs (34 bits)
package addr8u_chk_pkg;

  localparam int unsigned OP_W  = 8;
  localparam int unsigned SUM_W = 9;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } chk_state_e;

  typedef struct packed {
    logic [OP_W-1:0]  a;
    logic [OP_W-1:0]  b;
    logic [SUM_W-1:0] dut;
    logic [SUM_W-1:0] exp;
  } chk_log_t;

endpackage

// File: rtl/addr8u_chk_fifo.sv
// Synchronous FIFO of chk_log_t records with an occupancy count.
// Ports:
//   clk, rst (sync, active-high), clear (sync soft flush)
//   push/din : write a record (dropped only if full with no pop)
//   pop      : consume the head when valid
//   dout     : head record, valid while count != 0
//   count    : current occupancy, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap naturally.
module addr8u_chk_fifo
  import addr8u_chk_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW   = $clog2(DEPTH),
  localparam int unsigned CW   = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          push,
  input  chk_log_t      din,
  input  logic          pop,
  output chk_log_t      dout,
  output logic          valid,
  output logic [CW-1:0] count
);

  chk_log_t        mem [DEPTH];
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   wr_ptr;
  logic            do_pop;
  logic            do_push;

  // A pop in the same cycle frees the slot, so push into a full FIFO is legal then.
  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != CW'(DEPTH)) || do_pop);
  assign dout    = mem[rd_ptr];
  assign valid   = (count != '0);

  // Pointer and occupancy tracking.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage needs no reset; entries are only read once counted valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/addr8u_result_checker.sv
// Checker placed behind an 8-bit unsigned adder: recomputes A+B (9 bits),
// compares with the adder output, counts vectors/mismatches and captures
// the first failing vector. Two-stage pipeline: S1 registers the accepted
// vector, S2 compares; results appear two edges after the transfer.
// Optional build macro ADDR8U_CHK_LOG_EN adds a failing-vector log FIFO.
// Ports:
//   clk, rst (sync, active-high), clear (sync soft clear, wins over updates)
//   in_valid/in_ready : input handshake, transfer = in_valid & in_ready
//   in_a, in_b, dut_sum : operands and adder output for this vector
//   err_sticky, vec_count, err_count : status (counters saturate)
//   first_vld, first_a, first_b, first_sum, first_exp : first failure capture
//   log_valid, log_ready, log_data : log FIFO head (ADDR8U_CHK_LOG_EN only)
module addr8u_result_checker
  import addr8u_chk_pkg::*;
#(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned HALT_ON_ERR = 0,
  parameter int unsigned LOG_DEPTH   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  in_a,
  input  logic [OP_W-1:0]  in_b,
  input  logic [SUM_W-1:0] dut_sum,
  output logic             err_sticky,
  output logic [CNT_W-1:0] vec_count,
  output logic [CNT_W-1:0] err_count,
  output logic             first_vld,
  output logic [OP_W-1:0]  first_a,
  output logic [OP_W-1:0]  first_b,
  output logic [SUM_W-1:0] first_sum,
  output logic [SUM_W-1:0] first_exp
`ifdef ADDR8U_CHK_LOG_EN
  ,
  output logic                       log_valid,
  input  logic                       log_ready,
  output logic [$bits(chk_log_t)-1:0] log_data
`endif
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  if (LOG_DEPTH < 2 || (LOG_DEPTH & (LOG_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("LOG_DEPTH must be a power of two >= 2");
  end

  chk_state_e       state_q;
  chk_state_e       state_d;
  logic             log_space_ok;
  logic             xfer;
  logic             mismatch;
  logic [SUM_W-1:0] exp_sum;

  logic             s1_vld;
  logic [OP_W-1:0]  s1_a;
  logic [OP_W-1:0]  s1_b;
  logic [SUM_W-1:0] s1_dut;
  logic             s2_vld;
  logic [OP_W-1:0]  s2_a;
  logic [OP_W-1:0]  s2_b;
  logic [SUM_W-1:0] s2_dut;

  assign xfer     = in_valid && in_ready;
  assign exp_sum  = SUM_W'(s2_a) + SUM_W'(s2_b);
  assign mismatch = s2_vld && (exp_sum != s2_dut);

`ifdef ADDR8U_CHK_LOG_EN
  localparam int unsigned CW = $clog2(LOG_DEPTH) + 1;

  chk_log_t        log_entry;
  chk_log_t        log_head;
  logic [CW-1:0]   fifo_count;

  assign log_entry = '{a: s2_a, b: s2_b, dut: s2_dut, exp: exp_sum};
  assign log_data  = log_head;

  // Reserve a slot for every vector still in flight so a push never overflows.
  assign log_space_ok = ((CW+1)'(fifo_count) + (CW+1)'(s1_vld) + (CW+1)'(s2_vld))
                        < (CW+1)'(LOG_DEPTH);

  addr8u_chk_fifo #(
    .DEPTH (LOG_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clear (clear),
    .push  (mismatch && !clear),
    .din   (log_entry),
    .pop   (log_ready),
    .dout  (log_head),
    .valid (log_valid),
    .count (fifo_count)
  );
`else
  assign log_space_ok = 1'b1;
`endif

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= RUN;
    else     state_q <= state_d;
  end

  // FSM next state and handshake output.
  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    if (clear) begin
      state_d = RUN;
    end else if (state_q == RUN && mismatch && HALT_ON_ERR != 0) begin
      state_d = HALT;
    end
    in_ready = (state_q == RUN) && log_space_ok;
  end

  // S1/S2 pipeline; vectors in flight still drain while halted.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      s1_vld <= 1'b0;
      s1_a   <= '0;
      s1_b   <= '0;
      s1_dut <= '0;
      s2_vld <= 1'b0;
      s2_a   <= '0;
      s2_b   <= '0;
      s2_dut <= '0;
    end else begin
      s1_vld <= xfer;
      if (xfer) begin
        s1_a   <= in_a;
        s1_b   <= in_b;
        s1_dut <= dut_sum;
      end
      s2_vld <= s1_vld;
      s2_a   <= s1_a;
      s2_b   <= s1_b;
      s2_dut <= s1_dut;
    end
  end

  // Saturating counters, sticky flag and first-failure capture.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      vec_count  <= '0;
      err_count  <= '0;
      err_sticky <= 1'b0;
      first_vld  <= 1'b0;
      first_a    <= '0;
      first_b    <= '0;
      first_sum  <= '0;
      first_exp  <= '0;
    end else begin
      if (s2_vld && vec_count != CNT_MAX) vec_count <= vec_count + CNT_W'(1);
      if (mismatch) begin
        if (err_count != CNT_MAX) err_count <= err_count + CNT_W'(1);
        err_sticky <= 1'b1;
        if (!first_vld) begin
          first_vld <= 1'b1;
          first_a   <= s2_a;
          first_b   <= s2_b;
          first_sum <= s2_dut;
          first_exp <= exp_sum;
        end
      end
    end
  end

endmodule

// File: tb/tb_addr8u_result_checker.sv
// Self-checking bench for addr8u_result_checker: three instances share the
// stimulus (defaults, HALT_ON_ERR=1, CNT_W=4); each test resets or clears
// the instance it examines. The log FIFO test is built with ADDR8U_CHK_LOG_EN.
module tb_addr8u_result_checker;

  logic       clk;
  logic       rst;
  logic       clear;
  logic       in_valid;
  logic [7:0] in_a;
  logic [7:0] in_b;
  logic [8:0] dut_sum;
  logic       log_ready;

  logic        d0_in_ready, d0_err_sticky, d0_first_vld;
  logic [15:0] d0_vec_count, d0_err_count;
  logic [7:0]  d0_first_a, d0_first_b;
  logic [8:0]  d0_first_sum, d0_first_exp;

  logic        d1_in_ready, d1_err_sticky, d1_first_vld;
  logic [15:0] d1_vec_count, d1_err_count;
  logic [7:0]  d1_first_a, d1_first_b;
  logic [8:0]  d1_first_sum, d1_first_exp;

  logic        d2_in_ready, d2_err_sticky, d2_first_vld;
  logic [3:0]  d2_vec_count, d2_err_count;
  logic [7:0]  d2_first_a, d2_first_b;
  logic [8:0]  d2_first_sum, d2_first_exp;

`ifdef ADDR8U_CHK_LOG_EN
  logic        d0_log_valid, d1_log_valid, d2_log_valid;
  logic [33:0] d0_log_data, d1_log_data, d2_log_data;
`endif

  int checks   = 0;
  int failures = 0;

  addr8u_result_checker u_d0 (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(d0_in_ready),
    .in_a(in_a), .in_b(in_b), .dut_sum(dut_sum), .err_sticky(d0_err_sticky),
    .vec_count(d0_vec_count), .err_count(d0_err_count), .first_vld(d0_first_vld),
    .first_a(d0_first_a), .first_b(d0_first_b), .first_sum(d0_first_sum),
    .first_exp(d0_first_exp)
`ifdef ADDR8U_CHK_LOG_EN
    , .log_valid(d0_log_valid), .log_ready(log_ready), .log_data(d0_log_data)
`endif
  );

  addr8u_result_checker #(.HALT_ON_ERR(1)) u_d1 (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(d1_in_ready),
    .in_a(in_a), .in_b(in_b), .dut_sum(dut_sum), .err_sticky(d1_err_sticky),
    .vec_count(d1_vec_count), .err_count(d1_err_count), .first_vld(d1_first_vld),
    .first_a(d1_first_a), .first_b(d1_first_b), .first_sum(d1_first_sum),
    .first_exp(d1_first_exp)
`ifdef ADDR8U_CHK_LOG_EN
    , .log_valid(d1_log_valid), .log_ready(log_ready), .log_data(d1_log_data)
`endif
  );

  addr8u_result_checker #(.CNT_W(4)) u_d2 (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(d2_in_ready),
    .in_a(in_a), .in_b(in_b), .dut_sum(dut_sum), .err_sticky(d2_err_sticky),
    .vec_count(d2_vec_count), .err_count(d2_err_count), .first_vld(d2_first_vld),
    .first_a(d2_first_a), .first_b(d2_first_b), .first_sum(d2_first_sum),
    .first_exp(d2_first_exp)
`ifdef ADDR8U_CHK_LOG_EN
    , .log_valid(d2_log_valid), .log_ready(log_ready), .log_data(d2_log_data)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [8:0] dut;
    logic [8:0] exp;
    bit         bad;
  } vec_t;

  vec_t tbl [8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [33:0] act, input logic [33:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  initial begin
    int nerr;
`ifdef ADDR8U_CHK_LOG_EN
    int acc;
    logic [7:0]  ea;
    logic [33:0] eld;
`endif
    rst = 1'b1; clear = 1'b0; in_valid = 1'b0;
    in_a = '0; in_b = '0; dut_sum = '0; log_ready = 1'b1;

    tbl[0] = '{8'h7F, 8'h01, 9'h080, 9'h080, 1'b0};
    tbl[1] = '{8'hFF, 8'h80, 9'h07F, 9'h17F, 1'b1};
    tbl[2] = '{8'h00, 8'h00, 9'h000, 9'h000, 1'b0};
    tbl[3] = '{8'hFF, 8'hFF, 9'h1FE, 9'h1FE, 1'b0};
    tbl[4] = '{8'hFF, 8'h01, 9'h000, 9'h100, 1'b1};
    tbl[5] = '{8'h55, 8'hAA, 9'h0FF, 9'h0FF, 1'b0};
    tbl[6] = '{8'h80, 8'h80, 9'h100, 9'h100, 1'b0};
    tbl[7] = '{8'h01, 8'h02, 9'h013, 9'h003, 1'b1};

    repeat (3) tick();
    rst = 1'b0;
    tick();

    // Reset state
    check("rst_in_ready", 34'(d0_in_ready), 34'd1);
    check("rst_vec",      34'(d0_vec_count), 34'd0);
    check("rst_err",      34'(d0_err_count), 34'd0);
    check("rst_sticky",   34'(d0_err_sticky), 34'd0);
    check("rst_first",    34'(d0_first_vld), 34'd0);
    check("rst_ready_d1", 34'(d1_in_ready), 34'd1);

    // One vector at a time: latency and running counts
    nerr = 0;
    for (int i = 0; i < 8; i++) begin
      in_a = tbl[i].a; in_b = tbl[i].b; dut_sum = tbl[i].dut; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      check($sformatf("lat_vec[%0d]", i), 34'(d0_vec_count), 34'(i));
      tick();
      if (tbl[i].bad) nerr++;
      check($sformatf("vec[%0d]", i),    34'(d0_vec_count), 34'(i + 1));
      check($sformatf("err[%0d]", i),    34'(d0_err_count), 34'(nerr));
      check($sformatf("sticky[%0d]", i), 34'(d0_err_sticky), 34'(nerr != 0));
    end
    check("first_vld", 34'(d0_first_vld), 34'd1);
    check("first_a",   34'(d0_first_a),   34'(tbl[1].a));
    check("first_b",   34'(d0_first_b),   34'(tbl[1].b));
    check("first_sum", 34'(d0_first_sum), 34'h07F);
    check("first_exp", 34'(d0_first_exp), 34'(tbl[1].exp));

    // Same table back-to-back after clear
    pulse_clear();
    check("clr_vec", 34'(d0_vec_count), 34'd0);
    for (int i = 0; i < 8; i++) begin
      in_a = tbl[i].a; in_b = tbl[i].b; dut_sum = tbl[i].dut; in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    repeat (2) tick();
    check("b2b_vec",     34'(d0_vec_count), 34'd8);
    check("b2b_err",     34'(d0_err_count), 34'd3);
    check("b2b_first_a", 34'(d0_first_a),   34'hFF);
    check("b2b_first_e", 34'(d0_first_exp), 34'h17F);

    // Clear while a mismatch sits in S2
    pulse_clear();
    in_a = 8'hFF; in_b = 8'h80; dut_sum = 9'h07F; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    pulse_clear();
    check("t5_err",    34'(d0_err_count), 34'd0);
    check("t5_sticky", 34'(d0_err_sticky), 34'd0);
    check("t5_first",  34'(d0_first_vld), 34'd0);
    repeat (2) tick();
    check("t5_vec_late", 34'(d0_vec_count), 34'd0);
    check("t5_err_late", 34'(d0_err_count), 34'd0);

    // HALT_ON_ERR: mismatch then hold in_valid
    pulse_rst();
    in_a = 8'hFF; in_b = 8'h80; dut_sum = 9'h07F; in_valid = 1'b1;
    tick();
    check("t3_ready_k",  34'(d1_in_ready), 34'd1);
    tick();
    check("t3_ready_k1", 34'(d1_in_ready), 34'd1);
    tick();
    check("t3_ready_k2", 34'(d1_in_ready), 34'd0);
    check("t3_sticky",   34'(d1_err_sticky), 34'd1);
    repeat (8) tick();
    check("t3_vec",   34'(d1_vec_count), 34'd3);
    check("t3_err",   34'(d1_err_count), 34'd3);
    check("t3_ready", 34'(d1_in_ready), 34'd0);
    check("t3_fexp",  34'(d1_first_exp), 34'h17F);
    in_valid = 1'b0;
    pulse_clear();
    check("t3c_ready",  34'(d1_in_ready), 34'd1);
    check("t3c_vec",    34'(d1_vec_count), 34'd0);
    check("t3c_err",    34'(d1_err_count), 34'd0);
    check("t3c_sticky", 34'(d1_err_sticky), 34'd0);
    check("t3c_first",  34'(d1_first_vld), 34'd0);

    // CNT_W=4 saturation
    pulse_rst();
    in_a = 8'hFF; in_b = 8'h01; dut_sum = 9'h000; in_valid = 1'b1;
    repeat (20) tick();
    in_valid = 1'b0;
    repeat (3) tick();
    check("t4_vec", 34'(d2_vec_count), 34'hF);
    check("t4_err", 34'(d2_err_count), 34'hF);
    check("t4_fexp", 34'(d2_first_exp), 34'h100);

`ifdef ADDR8U_CHK_LOG_EN
    // Log FIFO back-pressure and ordering
    pulse_rst();
    log_ready = 1'b0;
    acc = 0;
    for (int c = 0; c < 12; c++) begin
      in_a = 8'h10 + 8'(acc); in_b = 8'h01; dut_sum = 9'h000; in_valid = 1'b1;
      if (d0_in_ready) acc++;
      tick();
    end
    check("t6_accepted", 34'(acc), 34'd4);
    check("t6_ready",    34'(d0_in_ready), 34'd0);
    check("t6_lvalid",   34'(d0_log_valid), 34'd1);
    check("t6_head",     d0_log_data, {8'h10, 8'h01, 9'h000, 9'h011});
    log_ready = 1'b1;
    tick();
    log_ready = 1'b0;
    for (int c = 0; c < 10; c++) begin
      in_a = 8'h10 + 8'(acc); in_b = 8'h01; dut_sum = 9'h000; in_valid = 1'b1;
      if (d0_in_ready) acc++;
      tick();
    end
    in_valid = 1'b0;
    repeat (3) tick();
    check("t6_accepted2", 34'(acc), 34'd5);
    check("t6_err",       34'(d0_err_count), 34'd5);
    for (int j = 0; j < 4; j++) begin
      ea  = 8'h11 + 8'(j);
      eld = {ea, 8'h01, 9'h000, 9'({1'b0, ea} + 9'h001)};
      check($sformatf("t6_lv[%0d]", j), 34'(d0_log_valid), 34'd1);
      check($sformatf("t6_ld[%0d]", j), d0_log_data, eld);
      log_ready = 1'b1;
      tick();
      log_ready = 1'b0;
    end
    check("t6_empty", 34'(d0_log_valid), 34'd0);
    log_ready = 1'b1;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
